// File: rtl/mdu_iter_if.sv
// mdu_iter_if: EX-stage handshake bundle for the multiply/divide unit.
// master = pipeline (start/op/a/b/cancel), slave = mdu (stall/busy/hi/lo).
interface mdu_iter_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              cancel;
  logic              stall;
  logic              busy;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  stall, busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output stall, busy, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: 1-cycle MULT/MULTU/MTHI/MTLO, iterative restoring DIV/DIVU.
// Ports: clk, rst (sync, active-low), bus (mdu_iter_if.slave).
module mdu_iter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic      clk,
  input logic      rst,
  mdu_iter_if.slave bus
);
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam int         MSB      = DATA_W - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_hi;
  logic [DATA_W-1:0]  r_lo;
  logic [DATA_W-1:0]  r_rem;
  logic [DATA_W-1:0]  r_quo;
  logic [DATA_W-1:0]  r_dvs;
  logic               r_qneg;
  logic               r_rneg;

  logic               w_go;
  logic               w_sdiv;
  logic               w_div_go;
  logic [DATA_W-1:0]  w_a_mag;
  logic [DATA_W-1:0]  w_b_mag;
  logic [2*DATA_W-1:0] w_sa;
  logic [2*DATA_W-1:0] w_sb;
  logic [2*DATA_W-1:0] w_ua;
  logic [2*DATA_W-1:0] w_ub;
  logic [2*DATA_W-1:0] w_prod_s;
  logic [2*DATA_W-1:0] w_prod_u;
  logic [DATA_W:0]    w_rem_sh;
  logic [DATA_W:0]    w_diff;
  logic               w_ge;

  assign w_go     = bus.start & ~bus.cancel
                  & (r_state == S_IDLE);
  assign w_sdiv   = (bus.op == OP_DIV);
  assign w_div_go = w_go
                  & (w_sdiv | (bus.op == OP_DIVU));

  assign w_a_mag = (w_sdiv & bus.a[MSB]) ? -bus.a : bus.a;
  assign w_b_mag = (w_sdiv & bus.b[MSB]) ? -bus.b : bus.b;

  // Low 2W bits of a 2W x 2W product are exact for
  // sign- or zero-extended W-bit operands.
  assign w_sa = {{DATA_W{bus.a[MSB]}}, bus.a};
  assign w_sb = {{DATA_W{bus.b[MSB]}}, bus.b};
  assign w_ua = {{DATA_W{1'b0}}, bus.a};
  assign w_ub = {{DATA_W{1'b0}}, bus.b};
  assign w_prod_s = w_sa * w_sb;
  assign w_prod_u = w_ua * w_ub;

  // Remainder stays below the divisor, so a W-bit register
  // suffices; the shifted value needs one extra bit.
  assign w_rem_sh = {r_rem, r_quo[MSB]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[DATA_W];

  assign bus.busy = (r_state != S_IDLE);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

  always_comb begin
    w_next    = r_state;
    bus.stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_div_go) begin
          w_next    = S_DIV;
          bus.stall = 1'b1;
        end
      end
      S_DIV: begin
        bus.stall = 1'b1;
        if (r_cnt == CNT_W'(1)) w_next = S_FIX;
      end
      S_FIX: begin
        bus.stall = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.cancel) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            case (bus.op)
              OP_MULT:  {r_hi, r_lo} <= w_prod_s;
              OP_MULTU: {r_hi, r_lo} <= w_prod_u;
              OP_MTHI:  r_hi <= bus.a;
              OP_MTLO:  r_lo <= bus.a;
              OP_DIV, OP_DIVU: begin
                r_quo  <= w_a_mag;
                r_dvs  <= w_b_mag;
                r_rem  <= '0;
                r_cnt  <= CNT_W'(DATA_W);
                r_qneg <= w_sdiv
                        & (bus.a[MSB] ^ bus.b[MSB]);
                r_rneg <= w_sdiv & bus.a[MSB];
              end
              default: ;
            endcase
          end
        end
        S_DIV: begin
          r_rem <= w_ge ? w_diff[MSB:0]
                        : w_rem_sh[MSB:0];
          r_quo <= {r_quo[MSB-1:0], w_ge};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          if (!bus.cancel) begin
            r_lo <= r_qneg ? -r_quo : r_quo;
            r_hi <= r_rneg ? -r_rem : r_rem;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: vector table, corner sequences and random ops
// checked against an arithmetic reference model (W=32 and W=16).
module tb_mdu_iter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mdu_iter_if #(.DATA_W(32)) m32 ();
  mdu_iter_if #(.DATA_W(16)) m16 ();

  mdu_iter #(.DATA_W(32), .CNT_W(6)) u32 (
    .clk(clk), .rst(rst), .bus(m32)
  );
  mdu_iter #(.DATA_W(16), .CNT_W(5)) u16 (
    .clk(clk), .rst(rst), .bus(m16)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          hold;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic longint sext(input logic [31:0] x,
                                  input int w);
    longint v;
    v = longint'(x);
    if (x[w-1]) v = v - (longint'(1) << w);
    return v;
  endfunction

  // Returns {hi, lo} after op, from plain integer arithmetic.
  function automatic logic [63:0] ref_op(
      input int w, input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] mask;
    logic [63:0] p;
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    mask = (64'd1 << w) - 64'd1;
    ua = 64'(a) & mask;
    ub = 64'(b) & mask;
    sa = sext(a, w);
    sb = sext(b, w);
    uq = 64'(lo);
    ur = 64'(hi);
    case (op)
      3'd1: begin
        p  = 64'(sa * sb);
        uq = p & mask;
        ur = (p >> w) & mask;
      end
      3'd2: begin
        p  = ua * ub;
        uq = p & mask;
        ur = (p >> w) & mask;
      end
      3'd3: begin
        if (sb == 0) begin
          uq = (sa < 0) ? 64'd1 : mask;
          ur = ua;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          uq = 64'(q) & mask;
          ur = 64'(r) & mask;
        end
      end
      3'd4: begin
        if (ub == 0) begin
          uq = mask;
          ur = ua;
        end else begin
          uq = ua / ub;
          ur = ua % ub;
        end
      end
      3'd5: ur = ua;
      3'd6: uq = ua;
      default: ;
    endcase
    return {ur[31:0], uq[31:0]};
  endfunction

  task automatic run32(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input bit hold,
                       output int n);
    n = 0;
    @(negedge clk);
    m32.start = 1'b1;
    m32.op = op;
    m32.a = a;
    m32.b = b;
    #1;
    if (m32.stall) n = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!hold || !m32.busy) begin
        m32.start = 1'b0;
        m32.op = 3'd0;
      end
      #1;
      if (!m32.stall) break;
      n++;
    end
  endtask

  task automatic run16(input logic [2:0] op,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       output int n);
    n = 0;
    @(negedge clk);
    m16.start = 1'b1;
    m16.op = op;
    m16.a = a;
    m16.b = b;
    #1;
    if (m16.stall) n = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      m16.start = 1'b0;
      m16.op = 3'd0;
      #1;
      if (!m16.stall) break;
      n++;
    end
  endtask

  task automatic chk_idle32(input string nm,
                            input logic [31:0] hi,
                            input logic [31:0] lo);
    chk({nm, "_stall"}, 32'(m32.stall), 32'd0);
    chk({nm, "_busy"}, 32'(m32.busy), 32'd0);
    chk({nm, "_hi"}, m32.hi, hi);
    chk({nm, "_lo"}, m32.lo, lo);
  endtask

  initial begin
    int n;
    logic [2:0]  op;
    logic [31:0] a, b, mhi, mlo;
    logic [63:0] e;

    tbl[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3, 1'b0,
                32'hFFFFFFFF, 32'hFFFFFFFA, 0};
    tbl[1]  = '{3'd2, 32'hFFFFFFFE, 32'd3, 1'b0,
                32'h00000002, 32'hFFFFFFFA, 0};
    tbl[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2, 1'b0,
                32'hFFFFFFFF, 32'hFFFFFFFD, 34};
    tbl[3]  = '{3'd4, 32'd100, 32'd7, 1'b0,
                32'd2, 32'd14, 34};
    tbl[4]  = '{3'd4, 32'd5, 32'd0, 1'b0,
                32'd5, 32'hFFFFFFFF, 34};
    tbl[5]  = '{3'd3, 32'd5, 32'd0, 1'b0,
                32'd5, 32'hFFFFFFFF, 34};
    tbl[6]  = '{3'd3, 32'hFFFFFFFB, 32'd0, 1'b0,
                32'hFFFFFFFB, 32'h00000001, 34};
    tbl[7]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0,
                32'd0, 32'h80000000, 34};
    tbl[8]  = '{3'd5, 32'hAB, 32'd9, 1'b0,
                32'hAB, 32'h80000000, 0};
    tbl[9]  = '{3'd6, 32'hCD, 32'd9, 1'b0,
                32'hAB, 32'hCD, 0};
    tbl[10] = '{3'd3, 32'd1000, 32'hFFFFFFFD, 1'b1,
                32'd1, 32'hFFFFFEB3, 34};

    m32.start = 0; m32.op = 0; m32.a = 0;
    m32.b = 0; m32.cancel = 0;
    m16.start = 0; m16.op = 0; m16.a = 0;
    m16.b = 0; m16.cancel = 0;

    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle32("rst0", 32'd0, 32'd0);
    chk("rst0_hi16", 32'(m16.hi), 32'd0);
    chk("rst0_busy16", 32'(m16.busy), 32'd0);

    foreach (tbl[i]) begin
      run32(tbl[i].op, tbl[i].a, tbl[i].b,
            tbl[i].hold, n);
      chk($sformatf("tbl%0d_n", i), 32'(n),
          32'(tbl[i].n));
      chk($sformatf("tbl%0d_hi", i), m32.hi, tbl[i].hi);
      chk($sformatf("tbl%0d_lo", i), m32.lo, tbl[i].lo);
    end
    @(negedge clk);
    #1;
    chk("hold_busy_after", 32'(m32.busy), 32'd0);

    run32(3'd5, 32'h11, 32'd0, 1'b0, n);
    run32(3'd6, 32'h22, 32'd0, 1'b0, n);
    chk_idle32("preset", 32'h11, 32'h22);

    // Cancel on DIV cycle 10.
    @(negedge clk);
    m32.start = 1; m32.op = 3'd3;
    m32.a = 32'd1000; m32.b = 32'd3;
    @(negedge clk);
    m32.start = 0; m32.op = 0;
    repeat (9) @(negedge clk);
    m32.cancel = 1;
    @(negedge clk);
    m32.cancel = 0;
    #1;
    chk_idle32("cxl_div", 32'h11, 32'h22);

    // Cancel during FIX.
    @(negedge clk);
    m32.start = 1; m32.op = 3'd4;
    m32.a = 32'd77; m32.b = 32'd5;
    @(negedge clk);
    m32.start = 0; m32.op = 0;
    repeat (32) @(negedge clk);
    m32.cancel = 1;
    @(negedge clk);
    m32.cancel = 0;
    #1;
    chk_idle32("cxl_fix", 32'h11, 32'h22);

    // Start and cancel together.
    @(negedge clk);
    m32.start = 1; m32.op = 3'd1; m32.cancel = 1;
    m32.a = 32'd5; m32.b = 32'd7;
    #1;
    chk("sc_mult_stall", 32'(m32.stall), 32'd0);
    @(negedge clk);
    m32.op = 3'd3;
    #1;
    chk("sc_div_stall", 32'(m32.stall), 32'd0);
    @(negedge clk);
    m32.start = 0; m32.op = 0; m32.cancel = 0;
    #1;
    chk_idle32("sc", 32'h11, 32'h22);

    // Reset on DIV cycle 5.
    @(negedge clk);
    m32.start = 1; m32.op = 3'd3;
    m32.a = 32'd100; m32.b = 32'd7;
    @(negedge clk);
    m32.start = 0; m32.op = 0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle32("rst_mid", 32'd0, 32'd0);

    mhi = 32'd0;
    mlo = 32'd0;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      e = ref_op(32, op, a, b, mhi, mlo);
      mhi = e[63:32];
      mlo = e[31:0];
      run32(op, a, b, 1'b0, n);
      chk($sformatf("rnd%0d_op%0d_n", i, op), 32'(n),
          (op == 3'd3 || op == 3'd4) ? 32'd34 : 32'd0);
      chk($sformatf("rnd%0d_op%0d_hi", i, op), m32.hi, mhi);
      chk($sformatf("rnd%0d_op%0d_lo", i, op), m32.lo, mlo);
    end

    run16(3'd3, 16'hFFF9, 16'd2, n);
    chk("w16_div_n", 32'(n), 32'd18);
    chk("w16_div_hi", 32'(m16.hi), 32'h0000FFFF);
    chk("w16_div_lo", 32'(m16.lo), 32'h0000FFFD);
    mhi = 32'(m16.hi);
    mlo = 32'(m16.lo);
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(1, 4));
      a = 32'($urandom_range(0, 16'hFFFF));
      b = (i % 4 == 0) ? 32'd0
                       : 32'($urandom_range(0, 16'hFFFF));
      e = ref_op(16, op, a, b, mhi, mlo);
      mhi = e[63:32];
      mlo = e[31:0];
      run16(op, a[15:0], b[15:0], n);
      chk($sformatf("w16_%0d_n", i), 32'(n),
          (op == 3'd3 || op == 3'd4) ? 32'd18 : 32'd0);
      chk($sformatf("w16_%0d_hi", i), 32'(m16.hi), mhi);
      chk($sformatf("w16_%0d_lo", i), 32'(m16.lo), mlo);
    end

    // Reset after activity, held two cycles.
    @(negedge clk);
    m32.start = 1; m32.op = 3'd4;
    m32.a = 32'd9; m32.b = 32'd2;
    @(negedge clk);
    m32.start = 0; m32.op = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle32("rst_end", 32'd0, 32'd0);
    chk("rst_end_lo16", 32'(m16.lo), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
